// File: rtl/trap_seq_pkg.sv
// trap_seq_pkg
// Shared types and constants for the trap/return sequencer.
//   trap_state_t  : sequencer state encoding
//   ecause_t      : synchronous exception cause codes (4 bits)
//   CSR_*         : machine CSR addresses used by the sequence
//   CSR_OP_*      : encoding of the csr port write field
//   IRQ_*         : machine interrupt cause numbers
package trap_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_TVAL,
        W_STATUS,
        R_TVEC,
        M_STATUS,
        M_EPC
    } trap_state_t;

    typedef enum logic [3:0] {
        EXC_I_ALIGN    = 4'd0,
        EXC_I_FAULT    = 4'd1,
        EXC_ILLEGAL    = 4'd2,
        EXC_BREAKPOINT = 4'd3,
        EXC_L_ALIGN    = 4'd4,
        EXC_L_FAULT    = 4'd5,
        EXC_S_ALIGN    = 4'd6,
        EXC_S_FAULT    = 4'd7,
        EXC_ECALL_U    = 4'd8,
        EXC_ECALL_S    = 4'd9,
        EXC_ECALL_M    = 4'd11,
        EXC_I_PFAULT   = 4'd12,
        EXC_L_PFAULT   = 4'd13,
        EXC_S_PFAULT   = 4'd15
    } ecause_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [1:0] CSR_OP_READ  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    localparam logic [4:0] IRQ_MSI = 5'd3;
    localparam logic [4:0] IRQ_MTI = 5'd7;
    localparam logic [4:0] IRQ_MEI = 5'd11;

    // Trap value for an exception: instruction-side faults and EBREAK report
    // the faulting byte address, ECALLs report nothing, everything else
    // reports the data supplied by writeback.
    function automatic logic [31:0] exc_tval(input logic [3:0]  cause,
                                             input logic [29:0] pc,
                                             input logic [31:0] data);
        logic [31:0] tval;
        case (cause)
            EXC_I_ALIGN, EXC_I_FAULT, EXC_I_PFAULT, EXC_BREAKPOINT: tval = {pc, 2'b00};
            EXC_ECALL_U, EXC_ECALL_S, EXC_ECALL_M:                  tval = '0;
            default:                                                tval = data;
        endcase
        return tval;
    endfunction

    // Apply a csr write/set/clear to the two shadowed mstatus bits {mpie, mie}.
    function automatic logic [1:0] shadow_apply(input logic [1:0] op,
                                                input logic [1:0] old,
                                                input logic [1:0] d);
        logic [1:0] res;
        case (op)
            CSR_OP_WRITE: res = d;
            CSR_OP_SET:   res = old | d;
            CSR_OP_CLEAR: res = old & ~d;
            default:      res = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/trap_seq_if.sv
// trap_pipe_if : pipeline side of the sequencer (CSR instruction requests,
//                writeback trap/return events, hold and redirect).
//                master = pipeline, slave = sequencer.
// trap_csr_if  : generic read/write port of the csr block.
//                master = sequencer, slave = csr block.
interface trap_pipe_if;
    logic        pipe_csr_valid;
    logic [11:0] pipe_csr_addr;
    logic [1:0]  pipe_csr_write;
    logic [31:0] pipe_csr_wdata;
    logic        pipe_csr_ready;
    logic [31:0] pipe_csr_rdata;
    logic        pipe_csr_error;
    logic        wb_valid;
    logic        wb_exc;
    logic [3:0]  wb_exc_cause;
    logic        wb_mret;
    logic [29:0] wb_pc;
    logic [31:0] wb_data;
    logic        trap_busy;
    logic        trap_setpc;
    logic [29:0] trap_newpc;

    modport master (
        output pipe_csr_valid, pipe_csr_addr, pipe_csr_write, pipe_csr_wdata,
        output wb_valid, wb_exc, wb_exc_cause, wb_mret, wb_pc, wb_data,
        input  pipe_csr_ready, pipe_csr_rdata, pipe_csr_error,
        input  trap_busy, trap_setpc, trap_newpc
    );

    modport slave (
        input  pipe_csr_valid, pipe_csr_addr, pipe_csr_write, pipe_csr_wdata,
        input  wb_valid, wb_exc, wb_exc_cause, wb_mret, wb_pc, wb_data,
        output pipe_csr_ready, pipe_csr_rdata, pipe_csr_error,
        output trap_busy, trap_setpc, trap_newpc
    );
endinterface

interface trap_csr_if;
    logic [11:0] csr_addr;
    logic [1:0]  csr_write;
    logic [31:0] csr_data_in;
    logic [31:0] csr_data_out;
    logic        csr_error;

    modport master (
        output csr_addr, csr_write, csr_data_in,
        input  csr_data_out, csr_error
    );

    modport slave (
        input  csr_addr, csr_write, csr_data_in,
        output csr_data_out, csr_error
    );
endinterface

// File: rtl/irq_sync_prio.sv
// irq_sync_prio
// Synchronises the three asynchronous machine interrupt lines and picks the
// highest-priority pending one (external > software > timer).
// Ports:
//   clk, reset          clock, async active-high reset
//   i_irq_ext/soft/timer raw level interrupt lines
//   o_irq_any           at least one synchronised line is high
//   o_cause             cause number of the winning line (0 when none)
module irq_sync_prio
    import trap_seq_pkg::*;
#(
    parameter int STAGES = 2
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_irq_ext,
    input  logic       i_irq_soft,
    input  logic       i_irq_timer,
    output logic       o_irq_any,
    output logic [4:0] o_cause
);

    // Bit order within each stage: [2] ext, [1] soft, [0] timer.
    logic [STAGES-1:0][2:0] r_sync;
    logic [2:0]             w_irq_raw;
    logic [2:0]             w_irq_synced;

    assign w_irq_raw = {i_irq_ext, i_irq_soft, i_irq_timer};

    generate
        if (STAGES == 1) begin : g_single
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_sync <= '0;
                else       r_sync <= w_irq_raw;
            end
        end else begin : g_chain
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_sync <= '0;
                else       r_sync <= {r_sync[STAGES-2:0], w_irq_raw};
            end
        end
    endgenerate

    assign w_irq_synced = r_sync[STAGES-1];
    assign o_irq_any    = |w_irq_synced;

    always_comb begin
        o_cause = '0;
        if (w_irq_synced[2])      o_cause = IRQ_MEI;
        else if (w_irq_synced[1]) o_cause = IRQ_MSI;
        else if (w_irq_synced[0]) o_cause = IRQ_MTI;
    end

endmodule

// File: rtl/trap_seq.sv
// trap_seq
// Trap/return sequencer and arbiter for the single csr read/write port.
// In IDLE the pipeline's CSR instructions pass straight through to the csr
// block; a retiring exception, MRET or enabled interrupt takes over the port
// for a fixed save/restore sequence while holding the pipeline.
// Ports:
//   clk, reset                 clock, async active-high reset
//   irq_ext/soft/timer         asynchronous level interrupt lines
//   pipe (trap_pipe_if.slave)  pipeline CSR requests, writeback events,
//                              trap_busy / trap_setpc / trap_newpc
//   csr  (trap_csr_if.master)  csr block generic port
// Build option:
//   TRAP_SEQ_VECTORED_EN  when defined, interrupts honour mtvec vectored
//                         mode (bit 0) and jump to base + cause.
//
// state    | meaning
// IDLE     | passthrough; watch writeback for trap/return
// W_EPC    | write mepc
// W_CAUSE  | write mcause
// W_TVAL   | write mtval
// W_STATUS | write mstatus (MPIE <- MIE, MIE <- 0)
// R_TVEC   | read mtvec, redirect, back to IDLE
// M_STATUS | MRET: write mstatus (MIE <- MPIE, MPIE <- 1)
// M_EPC    | MRET: read mepc, redirect, back to IDLE
module trap_seq
    import trap_seq_pkg::*;
#(
    parameter int IRQ_SYNC_STAGES = 2
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       irq_ext,
    input  logic       irq_soft,
    input  logic       irq_timer,
    trap_pipe_if.slave pipe,
    trap_csr_if.master csr
);

    trap_state_t r_state;
    trap_state_t w_state_next;

    logic        r_mie;
    logic        r_mpie;
    logic [29:0] r_epc;
    logic [31:0] r_cause_word;
    logic [31:0] r_tval;

    logic        w_irq_any;
    logic [4:0]  w_irq_cause;
    logic        w_exc_hit;
    logic        w_ret_hit;
    logic        w_irq_hit;
    logic        w_trap_start;
    logic        w_pipe_status_wr;
    logic [1:0]  w_status_new;
    logic [29:0] w_tvec_target;

    irq_sync_prio #(
        .STAGES (IRQ_SYNC_STAGES)
    ) u_irq_sync_prio (
        .clk         (clk),
        .reset       (reset),
        .i_irq_ext   (irq_ext),
        .i_irq_soft  (irq_soft),
        .i_irq_timer (irq_timer),
        .o_irq_any   (w_irq_any),
        .o_cause     (w_irq_cause)
    );

    // Arbitration order: exception, then MRET, then interrupt.
    assign w_exc_hit    = pipe.wb_valid & pipe.wb_exc;
    assign w_ret_hit    = pipe.wb_valid & ~pipe.wb_exc & pipe.wb_mret;
    assign w_irq_hit    = pipe.wb_valid & ~pipe.wb_exc & ~pipe.wb_mret & r_mie & w_irq_any;
    assign w_trap_start = w_exc_hit | w_ret_hit | w_irq_hit;

    assign w_pipe_status_wr = (r_state == IDLE) & ~w_trap_start & pipe.pipe_csr_valid
                            & (pipe.pipe_csr_write != CSR_OP_READ)
                            & (pipe.pipe_csr_addr == CSR_MSTATUS) & ~csr.csr_error;

    assign w_status_new = shadow_apply(pipe.pipe_csr_write, {r_mpie, r_mie},
                                       {pipe.pipe_csr_wdata[7], pipe.pipe_csr_wdata[3]});

`ifdef TRAP_SEQ_VECTORED_EN
    assign w_tvec_target = (r_cause_word[31] && csr.csr_data_out[0])
                         ? csr.csr_data_out[31:2] + {25'b0, r_cause_word[4:0]}
                         : csr.csr_data_out[31:2];
`else
    assign w_tvec_target = csr.csr_data_out[31:2];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_exc_hit || w_irq_hit) w_state_next = W_EPC;
                else if (w_ret_hit)         w_state_next = M_STATUS;
            end
            W_EPC:    w_state_next = W_CAUSE;
            W_CAUSE:  w_state_next = W_TVAL;
            W_TVAL:   w_state_next = W_STATUS;
            W_STATUS: w_state_next = R_TVEC;
            R_TVEC:   w_state_next = IDLE;
            M_STATUS: w_state_next = M_EPC;
            M_EPC:    w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_comb begin
        csr.csr_addr        = '0;
        csr.csr_write       = CSR_OP_READ;
        csr.csr_data_in     = '0;
        pipe.pipe_csr_ready = 1'b0;
        pipe.pipe_csr_rdata = '0;
        pipe.pipe_csr_error = 1'b0;
        pipe.trap_busy      = 1'b0;
        pipe.trap_setpc     = 1'b0;
        pipe.trap_newpc     = '0;
        case (r_state)
            IDLE: begin
                if (w_trap_start) begin
                    pipe.trap_busy = 1'b1;
                end else begin
                    csr.csr_addr        = pipe.pipe_csr_addr;
                    // No valid request must never turn into a stray write.
                    csr.csr_write       = pipe.pipe_csr_valid ? pipe.pipe_csr_write : CSR_OP_READ;
                    csr.csr_data_in     = pipe.pipe_csr_wdata;
                    pipe.pipe_csr_ready = pipe.pipe_csr_valid;
                    pipe.pipe_csr_rdata = csr.csr_data_out;
                    pipe.pipe_csr_error = csr.csr_error;
                end
            end
            W_EPC: begin
                pipe.trap_busy  = 1'b1;
                csr.csr_addr    = CSR_MEPC;
                csr.csr_write   = CSR_OP_WRITE;
                csr.csr_data_in = {r_epc, 2'b00};
            end
            W_CAUSE: begin
                pipe.trap_busy  = 1'b1;
                csr.csr_addr    = CSR_MCAUSE;
                csr.csr_write   = CSR_OP_WRITE;
                csr.csr_data_in = r_cause_word;
            end
            W_TVAL: begin
                pipe.trap_busy  = 1'b1;
                csr.csr_addr    = CSR_MTVAL;
                csr.csr_write   = CSR_OP_WRITE;
                csr.csr_data_in = r_tval;
            end
            W_STATUS: begin
                pipe.trap_busy  = 1'b1;
                csr.csr_addr    = CSR_MSTATUS;
                csr.csr_write   = CSR_OP_WRITE;
                csr.csr_data_in = {24'b0, r_mie, 7'b0};
            end
            R_TVEC: begin
                pipe.trap_busy  = 1'b1;
                pipe.trap_setpc = 1'b1;
                pipe.trap_newpc = w_tvec_target;
                csr.csr_addr    = CSR_MTVEC;
            end
            M_STATUS: begin
                pipe.trap_busy  = 1'b1;
                csr.csr_addr    = CSR_MSTATUS;
                csr.csr_write   = CSR_OP_WRITE;
                csr.csr_data_in = {24'b0, 1'b1, 3'b0, r_mpie, 3'b0};
            end
            M_EPC: begin
                pipe.trap_busy  = 1'b1;
                pipe.trap_setpc = 1'b1;
                pipe.trap_newpc = csr.csr_data_out[31:2];
                csr.csr_addr    = CSR_MEPC;
            end
            default: ;
        endcase
        // Outputs are forced quiet while reset is held so nothing reaches
        // the csr block or the pipeline during reset.
        if (reset) begin
            csr.csr_addr        = '0;
            csr.csr_write       = CSR_OP_READ;
            csr.csr_data_in     = '0;
            pipe.pipe_csr_ready = 1'b0;
            pipe.pipe_csr_rdata = '0;
            pipe.pipe_csr_error = 1'b0;
            pipe.trap_busy      = 1'b0;
            pipe.trap_setpc     = 1'b0;
            pipe.trap_newpc     = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mie        <= 1'b0;
            r_mpie       <= 1'b0;
            r_epc        <= '0;
            r_cause_word <= '0;
            r_tval       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_exc_hit) begin
                        r_epc        <= pipe.wb_pc;
                        r_cause_word <= {28'b0, pipe.wb_exc_cause};
                        r_tval       <= exc_tval(pipe.wb_exc_cause, pipe.wb_pc, pipe.wb_data);
                    end else if (w_irq_hit) begin
                        // Interrupt is taken after the retiring instruction.
                        r_epc        <= pipe.wb_pc + 30'd1;
                        r_cause_word <= {1'b1, 26'b0, w_irq_cause};
                        r_tval       <= '0;
                    end else if (w_pipe_status_wr) begin
                        r_mpie <= w_status_new[1];
                        r_mie  <= w_status_new[0];
                    end
                end
                W_STATUS: begin
                    r_mpie <= r_mie;
                    r_mie  <= 1'b0;
                end
                M_STATUS: begin
                    r_mie  <= r_mpie;
                    r_mpie <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_seq.sv
module tb_trap_seq;

    logic clk = 1'b0;
    logic reset;
    logic irq_ext, irq_soft, irq_timer;

    trap_pipe_if pif ();
    trap_csr_if  cif ();

    trap_seq dut (
        .clk       (clk),
        .reset     (reset),
        .irq_ext   (irq_ext),
        .irq_soft  (irq_soft),
        .irq_timer (irq_timer),
        .pipe      (pif.slave),
        .csr       (cif.master)
    );

    always #5 clk = ~clk;

    // Simple csr block stand-in: combinational read, write/set/clear on the
    // clock edge, mtvec comes from a bench variable.
    logic [31:0] csr_mem [0:4095] = '{default: '0};
    logic [31:0] m_mtvec;
    logic        force_err;

    assign cif.csr_data_out = (cif.csr_addr == 12'h305) ? m_mtvec : csr_mem[cif.csr_addr];
    assign cif.csr_error    = force_err && (cif.csr_addr == 12'h300);

    always @(posedge clk) begin
        if (cif.csr_write != 2'b00 && !cif.csr_error) begin
            case (cif.csr_write)
                2'b01:   csr_mem[cif.csr_addr] <= cif.csr_data_in;
                2'b10:   csr_mem[cif.csr_addr] <= csr_mem[cif.csr_addr] | cif.csr_data_in;
                default: csr_mem[cif.csr_addr] <= csr_mem[cif.csr_addr] & ~cif.csr_data_in;
            endcase
        end
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference state kept at the architectural level.
    bit          m_mie, m_mpie;
    logic [31:0] m_scratch = '0;
    logic [31:0] m_mepc = '0;

    logic [11:0] e_addr [5];
    logic [1:0]  e_op   [5];
    logic [31:0] e_data [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] op_apply(input logic [1:0] op, input logic [31:0] old, input logic [31:0] d);
        if (op == 2'b01) return d;
        if (op == 2'b10) return old | d;
        if (op == 2'b11) return old & ~d;
        return old;
    endfunction

    function automatic logic [31:0] ref_tval(input int cause, input logic [29:0] pc, input logic [31:0] data);
        if (cause == 0 || cause == 1 || cause == 3 || cause == 12) return {pc, 2'b00};
        if (cause == 8 || cause == 9 || cause == 11) return 32'h0;
        return data;
    endfunction

    task automatic drive_idle();
        pif.pipe_csr_valid = 1'b0;
        pif.pipe_csr_addr  = '0;
        pif.pipe_csr_write = 2'b00;
        pif.pipe_csr_wdata = '0;
        pif.wb_valid       = 1'b0;
        pif.wb_exc         = 1'b0;
        pif.wb_exc_cause   = '0;
        pif.wb_mret        = 1'b0;
        pif.wb_pc          = '0;
        pif.wb_data        = '0;
        force_err          = 1'b0;
    endtask

    task automatic pipe_op(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] d, input bit err);
        logic [31:0] st;
        @(negedge clk);
        drive_idle();
        force_err          = err;
        pif.pipe_csr_valid = 1'b1;
        pif.pipe_csr_addr  = addr;
        pif.pipe_csr_write = op;
        pif.pipe_csr_wdata = d;
        #1;
        chk("pipe_ready", pif.pipe_csr_ready, 1);
        chk("pipe_csr_write", cif.csr_write, op);
        chk("pipe_csr_addr", cif.csr_addr, addr);
        chk("pipe_csr_data", cif.csr_data_in, d);
        chk("pipe_busy", pif.trap_busy, 0);
        chk("pipe_error", pif.pipe_csr_error, err && addr == 12'h300);
        if (addr == 12'h340) chk("pipe_rdata", pif.pipe_csr_rdata, m_scratch);
        if (op != 2'b00 && !(err && addr == 12'h300)) begin
            if (addr == 12'h340) m_scratch = op_apply(op, m_scratch, d);
            if (addr == 12'h300) begin
                st     = op_apply(op, {24'b0, m_mpie, 3'b0, m_mie, 3'b0}, d);
                m_mie  = st[3];
                m_mpie = st[7];
            end
        end
    endtask

    task automatic capture_check(input string tag);
        chk({tag, "_busy"}, pif.trap_busy, 1);
        chk({tag, "_ready"}, pif.pipe_csr_ready, 0);
        chk({tag, "_csr_write"}, cif.csr_write, 2'b00);
        chk({tag, "_setpc"}, pif.trap_setpc, 0);
    endtask

    // Walk the sequence cycles, offering junk requests the sequencer must ignore.
    task automatic play_seq(input int n, input logic [29:0] newpc);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_idle();
            pif.pipe_csr_valid = 1'b1;
            pif.pipe_csr_addr  = 12'h340;
            pif.pipe_csr_write = 2'b01;
            pif.pipe_csr_wdata = $urandom;
            pif.wb_valid       = 1'($urandom_range(0, 1));
            pif.wb_exc         = 1'($urandom_range(0, 1));
            #1;
            chk("seq_addr", cif.csr_addr, e_addr[i]);
            chk("seq_write", cif.csr_write, e_op[i]);
            if (e_op[i] != 2'b00) chk("seq_data", cif.csr_data_in, e_data[i]);
            chk("seq_busy", pif.trap_busy, 1);
            chk("seq_ready", pif.pipe_csr_ready, 0);
            chk("seq_setpc", pif.trap_setpc, (i == n - 1));
            if (i == n - 1) chk("seq_newpc", pif.trap_newpc, newpc);
        end
    endtask

    task automatic exc_trap(input int cause, input logic [29:0] pc, input logic [31:0] data, input bit with_pipe);
        @(negedge clk);
        drive_idle();
        pif.wb_valid     = 1'b1;
        pif.wb_exc       = 1'b1;
        pif.wb_exc_cause = 4'(cause);
        pif.wb_pc        = pc;
        pif.wb_data      = data;
        pif.wb_mret      = 1'($urandom_range(0, 1));
        if (with_pipe) begin
            pif.pipe_csr_valid = 1'b1;
            pif.pipe_csr_addr  = 12'h340;
            pif.pipe_csr_write = 2'b01;
            pif.pipe_csr_wdata = $urandom;
        end
        #1;
        capture_check("exc_cap");
        e_addr[0] = 12'h341; e_op[0] = 2'b01; e_data[0] = {pc, 2'b00};
        e_addr[1] = 12'h342; e_op[1] = 2'b01; e_data[1] = 32'(cause);
        e_addr[2] = 12'h343; e_op[2] = 2'b01; e_data[2] = ref_tval(cause, pc, data);
        e_addr[3] = 12'h300; e_op[3] = 2'b01; e_data[3] = m_mie ? 32'h80 : 32'h0;
        e_addr[4] = 12'h305; e_op[4] = 2'b00; e_data[4] = '0;
        m_mepc = {pc, 2'b00};
        m_mpie = m_mie;
        m_mie  = 1'b0;
        play_seq(5, m_mtvec[31:2]);
    endtask

    task automatic irq_trap(input logic [2:0] lines, input logic [29:0] pc);
        int          cause;
        logic [29:0] target;
        @(negedge clk);
        drive_idle();
        {irq_ext, irq_soft, irq_timer} = lines;
        repeat (3) begin
            @(negedge clk);
            drive_idle();
            #1;
            chk("irq_wait_busy", pif.trap_busy, 0);
        end
        @(negedge clk);
        drive_idle();
        pif.wb_valid       = 1'b1;
        pif.wb_pc          = pc;
        pif.pipe_csr_valid = 1'($urandom_range(0, 1));
        pif.pipe_csr_addr  = 12'h340;
        pif.pipe_csr_write = 2'b10;
        pif.pipe_csr_wdata = $urandom;
        #1;
        capture_check("irq_cap");
        {irq_ext, irq_soft, irq_timer} = 3'b000;
        cause  = lines[2] ? 11 : (lines[1] ? 3 : 7);
        target = m_mtvec[31:2];
`ifdef TRAP_SEQ_VECTORED_EN
        if (m_mtvec[0]) target = m_mtvec[31:2] + 30'(cause);
`endif
        e_addr[0] = 12'h341; e_op[0] = 2'b01; e_data[0] = {pc + 30'd1, 2'b00};
        e_addr[1] = 12'h342; e_op[1] = 2'b01; e_data[1] = 32'h8000_0000 | 32'(cause);
        e_addr[2] = 12'h343; e_op[2] = 2'b01; e_data[2] = 32'h0;
        e_addr[3] = 12'h300; e_op[3] = 2'b01; e_data[3] = m_mie ? 32'h80 : 32'h0;
        e_addr[4] = 12'h305; e_op[4] = 2'b00; e_data[4] = '0;
        m_mepc = {pc + 30'd1, 2'b00};
        m_mpie = m_mie;
        m_mie  = 1'b0;
        play_seq(5, target);
    endtask

    task automatic mret_seq();
        @(negedge clk);
        drive_idle();
        pif.wb_valid       = 1'b1;
        pif.wb_mret        = 1'b1;
        pif.pipe_csr_valid = 1'($urandom_range(0, 1));
        pif.pipe_csr_addr  = 12'h340;
        pif.pipe_csr_write = 2'b11;
        pif.pipe_csr_wdata = $urandom;
        #1;
        capture_check("ret_cap");
        e_addr[0] = 12'h300; e_op[0] = 2'b01; e_data[0] = 32'h80 | (m_mpie ? 32'h8 : 32'h0);
        e_addr[1] = 12'h341; e_op[1] = 2'b00; e_data[1] = '0;
        m_mie  = m_mpie;
        m_mpie = 1'b1;
        play_seq(2, m_mepc[31:2]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] rpc;
        reset = 1'b1;
        {irq_ext, irq_soft, irq_timer} = 3'b000;
        m_mtvec = 32'h80;
        drive_idle();
        pif.pipe_csr_valid = 1'b1;
        pif.pipe_csr_addr  = 12'h340;
        pif.pipe_csr_write = 2'b01;
        pif.pipe_csr_wdata = 32'h1234_5678;
        m_mie  = 1'b0;
        m_mpie = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", pif.pipe_csr_ready, 0);
        chk("rst_csr_write", cif.csr_write, 0);
        chk("rst_csr_addr", cif.csr_addr, 0);
        chk("rst_busy", pif.trap_busy, 0);
        chk("rst_setpc", pif.trap_setpc, 0);
        chk("rst_newpc", pif.trap_newpc, 0);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();

        // Directed scenarios.
        pipe_op(12'h300, 2'b10, 32'h8, 1'b0);
        m_mtvec = 32'h80;
        exc_trap(2, 30'h100, 32'hdeadbeef, 1'b0);
        mret_seq();
        m_mtvec = 32'h81;
        irq_trap(3'b001, 30'h40);
        mret_seq();
        irq_trap(3'b010, 30'h3FFF_FFFF);
        mret_seq();
        pipe_op(12'h340, 2'b01, 32'hCAFE_0001, 1'b0);
        pipe_op(12'h340, 2'b00, 32'h0, 1'b0);
        pipe_op(12'h300, 2'b11, 32'h8, 1'b1);

        // Exception with a simultaneous pipe request, then reset in W_CAUSE.
        @(negedge clk);
        drive_idle();
        pif.wb_valid       = 1'b1;
        pif.wb_exc         = 1'b1;
        pif.wb_exc_cause   = 4'd5;
        pif.wb_pc          = 30'h222;
        pif.pipe_csr_valid = 1'b1;
        pif.pipe_csr_addr  = 12'h340;
        pif.pipe_csr_write = 2'b01;
        pif.pipe_csr_wdata = 32'hFFFF_FFFF;
        #1;
        capture_check("rstseq_cap");
        @(negedge clk);
        drive_idle();
        #1;
        chk("rstseq_w_epc", cif.csr_addr, 12'h341);
        m_mepc = {30'h222, 2'b00};
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        #1;
        chk("rstseq_csr_write", cif.csr_write, 0);
        chk("rstseq_busy", pif.trap_busy, 0);
        chk("rstseq_setpc", pif.trap_setpc, 0);
        @(negedge clk);
        reset  = 1'b0;
        m_mie  = 1'b0;
        m_mpie = 1'b0;
        repeat (4) begin
            @(negedge clk);
            drive_idle();
            #1;
            chk("post_rst_setpc", pif.trap_setpc, 0);
            chk("post_rst_busy", pif.trap_busy, 0);
            chk("post_rst_csr_write", cif.csr_write, 0);
        end

        // Interrupts pending with mie clear must not trap.
        {irq_ext, irq_soft, irq_timer} = 3'b101;
        repeat (3) @(negedge clk);
        drive_idle();
        pif.wb_valid       = 1'b1;
        pif.wb_pc          = 30'h50;
        pif.pipe_csr_valid = 1'b1;
        pif.pipe_csr_addr  = 12'h340;
        pif.pipe_csr_write = 2'b00;
        #1;
        chk("mie0_busy", pif.trap_busy, 0);
        chk("mie0_ready", pif.pipe_csr_ready, 1);
        chk("mie0_rdata", pif.pipe_csr_rdata, m_scratch);
        pipe_op(12'h300, 2'b10, 32'h8, 1'b0);
        irq_trap(3'b101, 30'h51);
        mret_seq();

        // Randomised mix.
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 3))
                0: begin
                    if ($urandom_range(0, 1) == 1)
                        pipe_op(12'h300, 2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) == 0));
                    else
                        pipe_op(12'h340, 2'($urandom_range(0, 3)), $urandom, 1'b0);
                end
                1: begin
                    m_mtvec = $urandom;
                    rpc     = 30'($urandom);
                    exc_trap(int'($urandom_range(0, 15)), rpc, $urandom, 1'($urandom_range(0, 1)));
                end
                2: begin
                    if (!m_mie) pipe_op(12'h300, 2'b10, 32'h8, 1'b0);
                    m_mtvec = $urandom;
                    rpc     = 30'($urandom);
                    irq_trap(3'($urandom_range(1, 7)), rpc);
                end
                default: mret_seq();
            endcase
        end

        @(negedge clk);
        drive_idle();
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trap_seq.md
Name: trap_seq

Overview:
- Trap/return sequencer and CSR-port arbiter in front of the csr block's generic read/write port (addr/write/data_in/data_out/error).
- Owns trap entry (exceptions and machine interrupts) and MRET, and shares the single CSR port between pipeline CSR instructions and its own multi-cycle save/restore sequence.
- Drives pipeline redirect and hold.
- Sits between writeback and csr.

Parameters:
IRQ_SYNC_STAGES, 2, synchroniser flops on each irq_* input (legal range 1..3)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
pipe_csr_valid  in  1  pipeline CSR instruction request
pipe_csr_addr  in  12  CSR address
pipe_csr_write  in  2  00 read, 01 write, 10 set, 11 clear
pipe_csr_wdata  in  32  operand
pipe_csr_ready  out  1  request performed this cycle
pipe_csr_rdata  out  32  old CSR value
pipe_csr_error  out  1  csr error passthrough
wb_valid  in  1  instruction retiring
wb_exc  in  1  retiring instruction raised exception
wb_exc_cause  in  4  ecause_t
wb_mret  in  1  retiring instruction is MRET
wb_pc  in  30  pc[31:2]
wb_data  in  32  fault address / instruction bits
irq_ext, irq_soft, irq_timer  in  1 each  level interrupt lines, asynchronous
csr_addr  out  12  to csr.addr
csr_write  out  2  to csr.write
csr_data_in  out  32  to csr.data_in
csr_data_out  in  32  from csr.data_out
csr_error  in  1  from csr.error
trap_busy  out  1  hold fetch/issue
trap_setpc  out  1  one-cycle redirect strobe
trap_newpc  out  30  redirect target [31:2]

Behaviour:
- Reset (async) forces:
  - state IDLE, shadow bits mie = 0 and mpie = 0, synchronisers cleared.
  - All outputs 0; csr_write = 00 (no CSR write).
  - Reset mid-sequence abandons the sequence with no further CSR writes.
- Shadow mstatus bits:
  - Updated on a granted pipe write to 0x300 with csr_error = 0. New value: write → d[3]/d[7]; set → old | d; clear → old & ~d.
  - Updated by trap entry and MRET as below.
- IDLE arbitration, evaluated in one cycle, first match wins:
  1. wb_valid & wb_exc → EXC.
  2. wb_valid & wb_mret → RET.
  3. wb_valid & mie & any synced irq → IRQ. Priority ext (cause 11) > soft (3) > timer (7).
  4. Otherwise pipe passthrough: csr_* = pipe_csr_*, pipe_csr_ready = pipe_csr_valid, pipe_csr_rdata = csr_data_out, pipe_csr_error = csr_error.
- On a trap match:
  - pipe_csr_ready = 0 and no CSR access that cycle.
  - trap_busy = 1 combinationally.
  - Latch into regs: epc, cause_word, tval.
- Latched values per trap kind:
  - EXC: epc = wb_pc; cause_word = {28'b0, cause}; tval = wb_pc for I-align/I-fault/I-pfault/EBREAK, 0 for ECALLs, wb_data otherwise.
  - IRQ: epc = wb_pc + 1; cause_word = {1'b1, 26'b0, 5-bit cause}; tval = 0.
- Trap states, one CSR access each:
  - W_EPC: write 0x341 ← {epc, 2'b00}.
  - W_CAUSE: write 0x342.
  - W_TVAL: write 0x343.
  - W_STATUS: write 0x300 ← bit7 = mie, bit3 = 0; then mpie ← mie, mie ← 0.
  - R_TVEC: read 0x305; trap_setpc = 1 with trap_newpc = csr_data_out[31:2]; → IDLE.
  - trap_setpc rises 5 cycles after the capture cycle.
- RET states:
  - M_STATUS: write 0x300 ← bit7 = 1, bit3 = mpie; mie ← mpie, mpie ← 1.
  - M_EPC: read 0x341; trap_setpc = 1 with trap_newpc = csr_data_out[31:2]; → IDLE.
  - Redirect 2 cycles after capture.
- Hold and errors:
  - trap_busy = 1 in every non-IDLE state; pipe_csr_ready = 0 there.
  - csr_error is ignored by the sequencer (all addresses it uses are implemented).
- Simultaneous events:
  - wb_exc with pipe_csr_valid: the exception wins and the pipe request is dropped, since the pipeline is flushed.
  - Exceptions and interrupts arriving while not IDLE are not sampled; writeback is held by trap_busy.
- Arithmetic:
  - wb_pc + 1 wraps modulo 2^30.
  - Interrupt cause fits in 5 bits; exception cause is 4 bits, zero-extended.

Optional Feature:
TRAP_SEQ_VECTORED_EN
- Defined: in R_TVEC, if the trap is an IRQ and csr_data_out[0] = 1, trap_newpc = csr_data_out[31:2] + cause (mod 2^30).
- Undefined: always the base; bit 0 of mtvec is ignored.

Decomposition:
- Shared package:
  - trap_state_t enum.
  - CSR address constants (CSR_MSTATUS 0x300, CSR_MTVEC 0x305, CSR_MEPC 0x341, CSR_MCAUSE 0x342, CSR_MTVAL 0x343).
  - IRQ cause constants (IRQ_MSI = 3, IRQ_MTI = 7, IRQ_MEI = 11).
  - ecause_t is reused from the existing package.
- Sub-module irq_sync_prio: per-line synchroniser chain plus fixed-priority encoder; outputs irq_any and cause[4:0].

Test Plan:
- Pipe set 0x300 with d = 0x8 in IDLE → ready same cycle, csr_write = 10; mie shadow = 1 next cycle.
- wb_exc, cause ILLEGAL (2), wb_pc = 0x100, wb_data = 0xdeadbeef, mtvec = 0x80 → CSR writes:
  - 0x341 ← 0x400, 0x342 ← 2, 0x343 ← 0xdeadbeef, 0x300 with bit7 = 1 (mie was 1), bit3 = 0.
  - trap_setpc in cycle 5 with newpc = 0x20.
- irq_timer high with mie = 1, wb_valid, wb_pc = 0x40 → after sync stages: mcause ← 0x80000007, mepc ← 0x104.
  - TRAP_SEQ_VECTORED_EN with mtvec = 0x81 → newpc = 0x27.
- wb_mret after the trap above → 0x300 written with bit3 = 1, bit7 = 1; trap_setpc 2 cycles later with mepc[31:2].
- Same-cycle wb_exc and pipe_csr_valid, then reset asserted in W_CAUSE → pipe_csr_ready = 0; on reset, state IDLE, no csr write, trap_setpc stays 0.
- irq_ext and irq_timer both high with mie = 0 → no trap; set mie → cause 11 taken first.
